// File: rtl/msx_snoop_capture_pkg.sv
// Shared types and constants for the MSX bus snooper.
// FSM states, event tags, VDP ports/selectors, SCC window decode.
package snoop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_R99  = 2'd1,
    ST_R9B  = 2'd2
  } state_t;

  localparam logic [7:0] TAG_SCC_9000 = 8'h08;
  localparam logic [7:0] TAG_SCC_98   = 8'h09;
  localparam logic [7:0] TAG_SCC_B000 = 8'h0A;
  localparam logic [7:0] TAG_SCC_B8   = 8'h0B;
  localparam logic [7:0] TAG_SCC_BFFE = 8'h0C;
  localparam logic [7:0] TAG_IO_BASE  = 8'h20;
  localparam int         VSYNC_BIT    = 23;

  localparam logic [7:0] VDP_CTRL = 8'h99;
  localparam logic [7:0] VDP_IND  = 8'h9B;
  localparam logic [7:0] SEL_R15  = 8'h8F;
  localparam logic [7:0] SEL_R17  = 8'h91;

  // Returns {hit, event}.
  function automatic logic [24:0] scc_decode(
    input logic [15:0] ad,
    input logic [7:0]  dt
  );
    logic [24:0] r;
    r = '0;
    unique case (1'b1)
      (ad == 16'h9000):
        r = {1'b1, TAG_SCC_9000, 8'h00, dt};
      (ad[15:8] == 8'h98):
        r = {1'b1, TAG_SCC_98, ad[7:0], dt};
      (ad == 16'hB000):
        r = {1'b1, TAG_SCC_B000, 8'h00, dt};
      (ad[15:8] == 8'hB8):
        r = {1'b1, TAG_SCC_B8, ad[7:0], dt};
      (ad == 16'hBFFE):
        r = {1'b1, TAG_SCC_BFFE, 8'hFE, dt};
      default:
        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/msx_snoop_capture_if.sv
// Event stream from the snooper to the capture FIFO.
// master drives ev_valid/ev_data, slave drives ev_ready.
interface msx_snoop_capture_if;
  logic        ev_valid;
  logic [23:0] ev_data;
  logic        ev_ready;

  modport master (
    output ev_valid,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_data,
    output ev_ready
  );
endinterface

// File: rtl/msx_snoop_capture_strobe_sync.sv
// Synchroniser plus single-cycle edge detector for one MSX strobe.
// Ports: sysclk, sys_n_reset, din (async strobe), pulse (1 cycle).
module snoop_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1  // 1: rising, 0: falling
) (
  input  logic sysclk,
  input  logic sys_n_reset,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   cur;

  assign cur = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sysclk or negedge sys_n_reset) begin
    if (!sys_n_reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= cur;
    end
  end

  assign pulse = EDGE ? (cur & ~last_q)
                      : (~cur & last_q);

endmodule

// File: rtl/msx_snoop_capture.sv
// MSX bus snooper: IO register pairs, VDP VSYNC, optional SCC (SNOOP_SCC_EN).
// Ports: sysclk, sys_n_reset, msx_* bus, ch_enable, ev (event stream), drop_count, frame_count.
module msx_snoop_capture
  import snoop_pkg::*;
#(
  parameter int                   SYNC_STAGES  = 2,
  parameter int                   NUM_IO_CH    = 3,
  parameter logic [NUM_IO_CH*8-1:0] IO_BASE    = {8'h7C, 8'hA0, 8'hC0},
  parameter logic [NUM_IO_CH*8-1:0] IO_REG_LIMIT = {8'hFF, 8'h0E, 8'hFF},
  parameter int                   DROP_W       = 16
) (
  input  logic                 sysclk,
  input  logic                 sys_n_reset,
  input  logic [7:0]           msx_dt,
  input  logic [15:0]          msx_ad,
  input  logic                 msx_n_sltsl,
  input  logic                 msx_n_iorq,
  input  logic                 msx_n_wr,
  input  logic                 msx_n_rd,
  input  logic [NUM_IO_CH-1:0] ch_enable,
  msx_snoop_capture_if.master  ev,
  output logic [DROP_W-1:0]    drop_count,
  output logic [22:0]          frame_count
);

  localparam int CH_W = (NUM_IO_CH > 1) ? $clog2(NUM_IO_CH) : 1;

  logic mem_wr, io_wr, io_rd;

  snoop_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_io_wr (
    .sysclk, .sys_n_reset,
    .din(~msx_n_iorq & ~msx_n_wr), .pulse(io_wr)
  );

  // Reads fire on release so the VDP-driven byte is settled.
  snoop_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_io_rd (
    .sysclk, .sys_n_reset,
    .din(~msx_n_iorq & ~msx_n_rd), .pulse(io_rd)
  );

`ifdef SNOOP_SCC_EN
  snoop_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_mem_wr (
    .sysclk, .sys_n_reset,
    .din(~msx_n_sltsl & ~msx_n_wr), .pulse(mem_wr)
  );
`else
  logic unused_scc;
  assign mem_wr = 1'b0;
  assign unused_scc = &{1'b0, msx_n_sltsl, msx_ad[15:8]};
`endif

  state_t      state;
  logic [7:0]  io_addr [NUM_IO_CH];
  logic [7:0]  r15, r17, ctrl_lo, ctrl_hi, ind_data;
  logic        ctrl_idx;
  logic        ev_valid_q;
  logic [23:0] ev_data_q;

  logic [7:0]      port;
  logic [CH_W-1:0] sel;
  logic            a_hit, d_hit;
  logic            addr_wr, ctrl_wr, ind_wr, vsync_hit;
  logic            emit, busy_drop, full_drop;
  logic [23:0]     emit_data;

  assign port = msx_ad[7:0];

  // Channel 0 sits in the top byte of IO_BASE/IO_REG_LIMIT.
  // Descending scan lets the lowest channel win overlaps.
  always_comb begin
    sel   = '0;
    a_hit = 1'b0;
    d_hit = 1'b0;
    for (int i = NUM_IO_CH - 1; i >= 0; i--) begin
      if (port == IO_BASE[(NUM_IO_CH-1-i)*8 +: 8]) begin
        a_hit = 1'b1;
        d_hit = 1'b0;
        sel   = CH_W'(i);
      end else if (port ==
                   IO_BASE[(NUM_IO_CH-1-i)*8 +: 8] + 8'd1) begin
        a_hit = 1'b0;
        d_hit = 1'b1;
        sel   = CH_W'(i);
      end
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_data = '0;
    addr_wr   = 1'b0;
    ctrl_wr   = 1'b0;
    ind_wr    = 1'b0;
    vsync_hit = 1'b0;
    if (state == ST_IDLE) begin
`ifdef SNOOP_SCC_EN
      if (mem_wr) begin
        {emit, emit_data} = scc_decode(msx_ad, msx_dt);
      end else
`endif
      if (io_wr) begin
        addr_wr = a_hit;
        ctrl_wr = !a_hit && !d_hit && port == VDP_CTRL;
        ind_wr  = !a_hit && !d_hit && port == VDP_IND;
        if (d_hit && ch_enable[sel] &&
            io_addr[sel] <
            IO_REG_LIMIT[(NUM_IO_CH-1-int'(sel))*8 +: 8]) begin
          emit      = 1'b1;
          emit_data = {TAG_IO_BASE + 8'(sel),
                       io_addr[sel], msx_dt};
        end
      end else if (io_rd) begin
        vsync_hit = port == VDP_CTRL && r15 == 8'h00 &&
                    msx_dt[7];
        if (vsync_hit) begin
          emit                 = 1'b1;
          emit_data[VSYNC_BIT] = 1'b1;
          emit_data[22:0]      = frame_count;
        end
      end
    end
  end

  assign busy_drop = state != ST_IDLE &&
                     (mem_wr || io_wr || io_rd);
  assign full_drop = emit && ev_valid_q && !ev.ev_ready;

  always_ff @(posedge sysclk or negedge sys_n_reset) begin
    if (!sys_n_reset) begin
      state       <= ST_IDLE;
      for (int i = 0; i < NUM_IO_CH; i++) io_addr[i] <= '0;
      r15         <= '0;
      r17         <= '0;
      ctrl_lo     <= '0;
      ctrl_hi     <= '0;
      ctrl_idx    <= 1'b0;
      ind_data    <= '0;
      ev_valid_q  <= 1'b0;
      ev_data_q   <= '0;
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (addr_wr) io_addr[sel] <= msx_dt;
          if (ctrl_wr) begin
            ctrl_idx <= ~ctrl_idx;
            if (!ctrl_idx) begin
              ctrl_lo <= msx_dt;
            end else begin
              ctrl_hi <= msx_dt;
              state   <= ST_R99;
            end
          end
          if (ind_wr) begin
            ind_data <= msx_dt;
            state    <= ST_R9B;
          end
          if (vsync_hit) frame_count <= frame_count + 1'b1;
        end
        ST_R99: begin
          if (ctrl_hi == SEL_R15) r15 <= ctrl_lo;
          else if (ctrl_hi == SEL_R17) r17 <= ctrl_lo;
          state <= ST_IDLE;
        end
        ST_R9B: begin
          if (r17[5:0] == 6'd15) r15 <= ind_data;
          if (r17[7:6] == 2'd0) r17 <= r17 + 8'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (emit && (!ev_valid_q || ev.ev_ready)) begin
        ev_valid_q <= 1'b1;
        ev_data_q  <= emit_data;
      end else if (ev_valid_q && ev.ev_ready) begin
        ev_valid_q <= 1'b0;
      end

      if ((busy_drop || full_drop) &&
          drop_count != {DROP_W{1'b1}})
        drop_count <= drop_count + 1'b1;
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_data  = ev_data_q;

endmodule

// File: tb/tb_msx_snoop_capture.sv
// Self-checking bench for msx_snoop_capture.
// Table vectors, hand sequences and random ops against a behavioural model.
module tb_msx_snoop_capture;

  logic        sysclk = 1'b0;
  logic        sys_n_reset = 1'b0;
  logic [7:0]  msx_dt = '0;
  logic [15:0] msx_ad = '0;
  logic        msx_n_sltsl = 1'b1;
  logic        msx_n_iorq = 1'b1;
  logic        msx_n_wr = 1'b1;
  logic        msx_n_rd = 1'b1;
  logic [2:0]  ch_enable = 3'b111;
  logic [15:0] drop_count;
  logic [22:0] frame_count;

  msx_snoop_capture_if ev();

  msx_snoop_capture dut (
    .sysclk      (sysclk),
    .sys_n_reset (sys_n_reset),
    .msx_dt      (msx_dt),
    .msx_ad      (msx_ad),
    .msx_n_sltsl (msx_n_sltsl),
    .msx_n_iorq  (msx_n_iorq),
    .msx_n_wr    (msx_n_wr),
    .msx_n_rd    (msx_n_rd),
    .ch_enable   (ch_enable),
    .ev          (ev),
    .drop_count  (drop_count),
    .frame_count (frame_count)
  );

  always #5 sysclk = ~sysclk;

`ifdef SNOOP_SCC_EN
  localparam bit SCC = 1'b1;
`else
  localparam bit SCC = 1'b0;
`endif

  localparam int IOW = 0;
  localparam int IOR = 1;
  localparam int MEM = 2;

  int checks = 0;
  int errors = 0;

  logic [23:0] obs_q[$];

  always @(negedge sysclk)
    if (ev.ev_valid && ev.ev_ready) obs_q.push_back(ev.ev_data);

  // Behavioural model
  logic [7:0]  base [3] = '{8'h7C, 8'hA0, 8'hC0};
  logic [7:0]  lim  [3] = '{8'hFF, 8'h0E, 8'hFF};
  logic [7:0]  m_addr [3];
  logic [7:0]  m_r15, m_r17, m_lo;
  bit          m_idx;
  logic [22:0] m_frame;
  int          m_drop;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_addr[i] = 8'h00;
    m_r15 = 0; m_r17 = 0; m_lo = 0; m_idx = 0;
    m_frame = 0; m_drop = 0;
  endtask

  task automatic model_op(input int kind, input logic [15:0] a,
                          input logic [7:0] d, output bit e,
                          output logic [23:0] x);
    bit hit;
    logic [7:0] p;
    e = 0; x = '0; hit = 0; p = a[7:0];
    if (kind == IOW) begin
      for (int i = 0; i < 3; i++) begin
        if (!hit && p == base[i]) begin
          m_addr[i] = d; hit = 1;
        end else if (!hit && p == base[i] + 8'd1) begin
          hit = 1;
          if (ch_enable[i] && m_addr[i] < lim[i]) begin
            e = 1;
            x = {8'h20 + 8'(i), m_addr[i], d};
          end
        end
      end
      if (!hit && p == 8'h99) begin
        if (!m_idx) m_lo = d;
        else if (d == 8'h8F) m_r15 = m_lo;
        else if (d == 8'h91) m_r17 = m_lo;
        m_idx = !m_idx;
      end else if (!hit && p == 8'h9B) begin
        if (m_r17[5:0] == 6'd15) m_r15 = d;
        if (m_r17[7:6] == 2'd0) m_r17 = m_r17 + 8'd1;
      end
    end else if (kind == IOR) begin
      if (p == 8'h99 && m_r15 == 0 && d[7]) begin
        e = 1; x = {1'b1, m_frame}; m_frame = m_frame + 1;
      end
    end else if (SCC) begin
      if (a == 16'h9000) begin e = 1; x = {16'h0800, d}; end
      else if (a[15:8] == 8'h98) begin e = 1; x = {8'h09, a[7:0], d}; end
      else if (a == 16'hB000) begin e = 1; x = {16'h0A00, d}; end
      else if (a[15:8] == 8'hB8) begin e = 1; x = {8'h0B, a[7:0], d}; end
      else if (a == 16'hBFFE) begin e = 1; x = {16'h0CFE, d}; end
    end
  endtask

  // Bus cycles
  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic bus_op(input int kind, input logic [15:0] a,
                        input logic [7:0] d);
    msx_ad = a; msx_dt = d;
    cyc(1);
    if (kind == MEM) begin
      msx_n_sltsl = 0; msx_n_wr = 0; cyc(4);
      msx_n_sltsl = 1; msx_n_wr = 1; cyc(4);
    end else if (kind == IOW) begin
      msx_n_iorq = 0; msx_n_wr = 0; cyc(4);
      msx_n_iorq = 1; msx_n_wr = 1; cyc(4);
    end else begin
      msx_n_iorq = 0; msx_n_rd = 0; cyc(4);
      msx_n_iorq = 1; msx_n_rd = 1; cyc(5);
    end
  endtask

  task automatic run_op(input int kind, input logic [15:0] a,
                        input logic [7:0] d, output bit e,
                        output logic [23:0] x);
    bus_op(kind, a, d);
    model_op(kind, a, d, e, x);
  endtask

  task automatic cmp_obs(input string name, input bit e,
                         input logic [23:0] x);
    logic [23:0] f;
    f = (obs_q.size() > 0) ? obs_q[0] : 24'h0;
    checks++;
    if (e ? (obs_q.size() != 1 || f !== x) : (obs_q.size() != 0)) begin
      errors++;
      $display("FAIL %s: got %0d events (first %h), want %0d (%h)",
               name, obs_q.size(), f, e, x);
    end
    obs_q.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [7:0]  d;
    bit          e;
    logic [23:0] x;
  } vec_t;

  vec_t vt[$];

  initial begin
    bit          e;
    logic [23:0] x;
    logic [7:0]  ports [10] = '{8'h7C, 8'h7D, 8'hA0, 8'hA1, 8'hC0,
                                8'hC1, 8'h99, 8'h9B, 8'h7E, 8'h98};
    logic [7:0]  vals [6] = '{8'h00, 8'h80, 8'h0F, 8'h8F,
                              8'h91, 8'h0E};
    logic [15:0] maddr [6] = '{16'h9000, 16'h9001, 16'h9800,
                               16'hB000, 16'hB800, 16'hBFFE};

    vt.push_back('{IOW, 16'h007C, 8'h10, 0, 24'h0});
    vt.push_back('{IOW, 16'h007D, 8'h55, 1, 24'h201055});
    vt.push_back('{IOW, 16'h00A0, 8'h0E, 0, 24'h0});
    vt.push_back('{IOW, 16'h00A1, 8'h3F, 0, 24'h0});
    vt.push_back('{IOW, 16'h00A0, 8'h07, 0, 24'h0});
    vt.push_back('{IOW, 16'h00A1, 8'hB8, 1, 24'h2107B8});
    vt.push_back('{IOW, 16'h0099, 8'h00, 0, 24'h0});
    vt.push_back('{IOW, 16'h0099, 8'h8F, 0, 24'h0});
    vt.push_back('{IOR, 16'h0099, 8'h80, 1, 24'h800000});
    vt.push_back('{IOR, 16'h0099, 8'h80, 1, 24'h800001});
    vt.push_back('{IOW, 16'h0099, 8'h01, 0, 24'h0});
    vt.push_back('{IOW, 16'h0099, 8'h8F, 0, 24'h0});
    vt.push_back('{IOR, 16'h0099, 8'h80, 0, 24'h0});
    vt.push_back('{IOW, 16'h0099, 8'h0F, 0, 24'h0});
    vt.push_back('{IOW, 16'h0099, 8'h91, 0, 24'h0});
    vt.push_back('{IOW, 16'h009B, 8'h00, 0, 24'h0});
    vt.push_back('{IOR, 16'h0099, 8'h80, 1, 24'h800002});
    vt.push_back('{IOR, 16'h0099, 8'h7F, 0, 24'h0});
    vt.push_back('{IOW, 16'h00C0, 8'hFE, 0, 24'h0});
    vt.push_back('{IOW, 16'h00C1, 8'h12, 1, 24'h22FE12});
    vt.push_back('{IOW, 16'h00C0, 8'hFF, 0, 24'h0});
    vt.push_back('{IOW, 16'h00C1, 8'h34, 0, 24'h0});
    vt.push_back('{MEM, 16'h9812, 8'h7A, SCC, 24'h09127A});
    vt.push_back('{MEM, 16'h9001, 8'h55, 0, 24'h0});
    vt.push_back('{MEM, 16'hBFFE, 8'h33, SCC, 24'h0CFE33});
    vt.push_back('{MEM, 16'h9000, 8'h44, SCC, 24'h080044});

    model_reset();
    ev.ev_ready = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(ev.ev_valid), 0);
    chk("rst_data", 32'(ev.ev_data), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_frame", 32'(frame_count), 0);
    sys_n_reset = 1'b1;
    cyc(2);

    foreach (vt[i]) begin
      run_op(vt[i].kind, vt[i].a, vt[i].d, e, x);
      cmp_obs($sformatf("vec%0d", i), vt[i].e, vt[i].x);
    end
    chk("frame_after_table", 32'(frame_count), 3);

    // Channel enable gates data writes only
    ch_enable = 3'b110;
    run_op(IOW, 16'h007D, 8'h66, e, x);
    cmp_obs("ch0_disabled", 0, 24'h0);
    ch_enable = 3'b111;
    run_op(IOW, 16'h007D, 8'h66, e, x);
    cmp_obs("ch0_reenabled", 1, 24'h201066);

    // Backpressure: first event held, later ones dropped
    ev.ev_ready = 1'b0;
    run_op(IOW, 16'h007C, 8'h10, e, x);
    run_op(IOW, 16'h007D, 8'h01, e, x);
    run_op(IOW, 16'h007D, 8'h02, e, x);
    run_op(IOW, 16'h007D, 8'h03, e, x);
    m_drop += 2;
    chk("bp_valid", 32'(ev.ev_valid), 1);
    chk("bp_data", 32'(ev.ev_data), 32'h201001);
    chk("bp_drop", 32'(drop_count), 2);
    ev.ev_ready = 1'b1;
    @(negedge sysclk);
    @(negedge sysclk);
    chk("bp_release", 32'(ev.ev_valid), 0);
    cmp_obs("bp_drain", 1, 24'h201001);

    // Read strobe landing in the cycle after the 2nd 0x99 byte
    run_op(IOW, 16'h0099, 8'h00, e, x);
    msx_ad = 16'h0099; msx_dt = 8'h8F;
    msx_n_iorq = 0; msx_n_rd = 0; cyc(4);
    msx_n_wr = 0; cyc(1);
    msx_n_rd = 1; cyc(5);
    msx_n_iorq = 1; msx_n_wr = 1; cyc(4);
    model_op(IOW, 16'h0099, 8'h8F, e, x);
    m_drop += 1;
    cmp_obs("busy_no_event", 0, 24'h0);
    chk("busy_drop", 32'(drop_count), 32'(m_drop));
    chk("busy_frame", 32'(frame_count), 32'(m_frame));

    // Random ops against the model
    for (int n = 0; n < 200; n++) begin
      int k;
      logic [7:0] d;
      logic [15:0] a;
      k = $urandom_range(0, 9);
      d = ($urandom_range(0, 1) == 1) ? vals[$urandom_range(0, 5)]
                                      : 8'($urandom);
      if (k <= 5) begin
        a = {8'h00, ports[$urandom_range(0, 9)]};
        run_op(IOW, a, d, e, x);
        cmp_obs($sformatf("rnd%0d_iow_%h", n, a[7:0]), e, x);
      end else if (k <= 7) begin
        run_op(IOR, 16'h0099, d, e, x);
        cmp_obs($sformatf("rnd%0d_ior", n), e, x);
      end else if (k == 8) begin
        a = maddr[$urandom_range(0, 5)] | 16'($urandom_range(0, 3));
        run_op(MEM, a, d, e, x);
        cmp_obs($sformatf("rnd%0d_mem_%h", n, a), e, x);
      end else begin
        ch_enable = 3'($urandom);
      end
    end
    chk("rnd_frame", 32'(frame_count), 32'(m_frame));
    chk("rnd_drop", 32'(drop_count), 32'(m_drop));

    // Reset in the middle of a 0x99 pair
    ch_enable = 3'b111;
    run_op(IOW, 16'h0099, 8'h05, e, x);
    sys_n_reset = 1'b0;
    cyc(2);
    chk("mid_rst_valid", 32'(ev.ev_valid), 0);
    chk("mid_rst_drop", 32'(drop_count), 0);
    chk("mid_rst_frame", 32'(frame_count), 0);
    sys_n_reset = 1'b1;
    model_reset();
    obs_q.delete();
    cyc(2);
    run_op(IOW, 16'h0099, 8'h8F, e, x);
    cmp_obs("post_rst_byte0", 0, 24'h0);
    run_op(IOR, 16'h0099, 8'h80, e, x);
    cmp_obs("post_rst_vsync", 1, 24'h800000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
